// File: rtl/ram_arbiter.sv
// Arbitrates one variable-latency RAM between instruction (i*) and data (d*) requesters.
// Latency: one IDLE bubble, then RAM latency; ack (xwait low) on the ACCESS cycle.
// Backpressure: a grant is held until ACCESS, a request drop, or TIMEOUT. RAM_ARB_RR_EN selects round-robin.
module ram_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    // ramstate_t encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);

    state_t        state, next_state;
    logic [CW-1:0] tcnt;
    logic          rr_last_i;

    logic ireq, dreq, granted, access, req_held, timeout;

    assign ireq     = iREN;
    assign dreq     = dREN | dWEN;
    assign granted  = (state != IDLE);
    assign access   = granted && (ramstate == RAM_ACCESS);
    assign req_held = (state == GRANT_I) ? ireq : dreq;
    // A drop in the same cycle as the last wait cycle is a drop, not a timeout.
    assign timeout  = granted && !access && req_held && (tcnt == TO_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
`ifdef RAM_ARB_RR_EN
                if (dreq && ireq) begin
                    next_state = rr_last_i ? GRANT_D : GRANT_I;
                end else if (dreq) begin
                    next_state = GRANT_D;
                end else if (ireq) begin
                    next_state = GRANT_I;
                end
`else
                if (dreq) begin
                    next_state = GRANT_D;
                end else if (ireq) begin
                    next_state = GRANT_I;
                end
`endif
            end
            GRANT_I, GRANT_D: begin
                if (access || !req_held || timeout) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state)
            GRANT_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = !access;
            end
            GRANT_D: begin
                // Simultaneous read and write is taken as a write.
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = !access;
            end
            default: ;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tcnt      <= '0;
            err       <= 1'b0;
            rr_last_i <= 1'b1;
        end else begin
            if (!granted) begin
                tcnt <= '0;
            end else if (!access && (tcnt < TO_MAX)) begin
                tcnt <= tcnt + 1'b1;
            end
            if ((granted && (ramstate == RAM_ERROR)) || timeout) begin
                err <= 1'b1;
            end
            rr_last_i <= access ? (state == GRANT_I) : rr_last_i;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM with programmable latency and error injection,
// plus an ack scoreboard that checks the side and the read data of every ack.
`timescale 1ns/1ps
module tb_ram_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic        err;

    always #5 CLK = ~CLK;

    ram_arbiter #(.TIMEOUT(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    typedef struct {
        bit          is_d;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   n_ack_i = 0, n_ack_d = 0, ack_cyc_i = 0, ack_cyc_d = 0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Behavioural RAM: ACCESS after lat enabled cycles; one tracked write location.
    int          lat = 1;
    int          lcnt = 0;
    bit          inj = 1'b0;
    bit          wr_vld = 1'b0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    logic        en, ram_access;

    assign en         = ramREN | ramWEN;
    assign ram_access = en && !inj && (lcnt + 1 >= lat);
    assign ramstate   = inj ? 2'd3 : ram_access ? 2'd2 : en ? 2'd1 : 2'd0;
    assign ramload    = (wr_vld && ramaddr == wr_addr) ? wr_data : pat(ramaddr);

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!en || ram_access) lcnt <= 0;
        else                   lcnt <= lcnt + 1;
        if (ram_access && ramWEN) begin
            wr_vld  <= 1'b1;
            wr_addr <= ramaddr;
            wr_data <= ramstore;
        end
    end

    task automatic monitor();
        exp_t        e;
        bit          got_d;
        logic [31:0] got;
        forever begin
            @(negedge CLK);
            if (!iwait || !dwait) begin
                checks++;
                got_d = !dwait;
                got   = got_d ? dload : iload;
                if (!iwait && !dwait) begin
                    $display("FAIL ack_exclusive: iwait=%b dwait=%b, required at most one low", iwait, dwait);
                end else if (sbq.size() == 0) begin
                    $display("FAIL unexpected_ack: side_d=%b at cycle %0d, required no ack", got_d, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (got_d !== e.is_d || (e.chk && got !== e.data))
                        $display("FAIL ack_order_data: side_d=%b data=%h, required side_d=%b data=%h",
                                 got_d, got, e.is_d, e.data);
                    else
                        passed++;
                end
                if (!iwait) begin n_ack_i++; ack_cyc_i = cyc; end
                if (!dwait) begin n_ack_d++; ack_cyc_d = cyc; end
            end
        end
    endtask

    task automatic wait_acks(input int target, input int maxc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            @(posedge CLK);
            if (n_ack_i + n_ack_d >= target) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0; inj = 0; lat = 1;
        nRST = 1'b1;
        #1 nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge CLK);
        checks++; if (iwait !== 1'b1)   $display("FAIL rst_iwait: got %b, required 1", iwait); else passed++;
        checks++; if (dwait !== 1'b1)   $display("FAIL rst_dwait: got %b, required 1", dwait); else passed++;
        checks++; if (ramREN !== 1'b0)  $display("FAIL rst_ramREN: got %b, required 0", ramREN); else passed++;
        checks++; if (ramWEN !== 1'b0)  $display("FAIL rst_ramWEN: got %b, required 0", ramWEN); else passed++;
        checks++; if (ramaddr !== '0)   $display("FAIL rst_ramaddr: got %h, required 0", ramaddr); else passed++;
        checks++; if (ramstore !== '0)  $display("FAIL rst_ramstore: got %h, required 0", ramstore); else passed++;
        checks++; if (err !== 1'b0)     $display("FAIL rst_err: got %b, required 0", err); else passed++;
    endtask

    task automatic test_single_read();
        int base, c0;
        bit ok;
        do_reset();
        base = n_ack_i + n_ack_d;
        sbq.push_back('{1'b1, 1'b1, pat(32'h40)});
        @(posedge CLK); #1;
        c0 = cyc; daddr = 32'h40; dREN = 1'b1;
        wait_acks(base + 1, 20, ok);
        dREN = 1'b0;
        checks++; if (ok !== 1'b1) $display("FAIL single_ack_seen: got %b, required 1", ok); else passed++;
        checks++; if (ack_cyc_d - c0 !== 1) $display("FAIL single_latency: got %0d, required 1", ack_cyc_d - c0); else passed++;
        checks++; if (sbq.size() !== 0) $display("FAIL single_drain: got %0d pending, required 0", sbq.size()); else passed++;
    endtask

    task automatic test_fixed_prio_write();
        int base;
        bit ok1, ok2;
        do_reset();
        base = n_ack_i + n_ack_d;
        sbq.push_back('{1'b1, 1'b0, 32'h0});
        sbq.push_back('{1'b0, 1'b1, pat(32'h100)});
        @(posedge CLK); #1;
        iREN = 1'b1; iaddr = 32'h100; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEADBEEF;
        wait_acks(base + 1, 20, ok1);
        dWEN = 1'b0;
        wait_acks(base + 2, 20, ok2);
        iREN = 1'b0;
        checks++; if ({ok1, ok2} !== 2'b11) $display("FAIL prio_acks_seen: got %b, required 11", {ok1, ok2}); else passed++;
        checks++; if (ack_cyc_i - ack_cyc_d !== 2) $display("FAIL prio_bubble: got %0d cycles, required 2", ack_cyc_i - ack_cyc_d); else passed++;
        checks++; if (!(wr_vld && wr_addr == 32'h80 && wr_data == 32'hDEADBEEF))
            $display("FAIL prio_write: got vld=%b addr=%h data=%h, required 1/00000080/deadbeef", wr_vld, wr_addr, wr_data);
        else passed++;
        checks++; if (sbq.size() !== 0) $display("FAIL prio_drain: got %0d pending, required 0", sbq.size()); else passed++;
    endtask

    task automatic test_both_held();
        int base;
        bit ok;
        bit sides [4];
`ifdef RAM_ARB_RR_EN
        sides = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        sides = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        do_reset();
        base = n_ack_i + n_ack_d;
        for (int k = 0; k < 4; k++)
            sbq.push_back('{sides[k], 1'b1, sides[k] ? pat(32'h44) : pat(32'h200)});
        @(posedge CLK); #1;
        iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h44;
        wait_acks(base + 4, 60, ok);
        iREN = 1'b0; dREN = 1'b0;
        checks++; if (ok !== 1'b1) $display("FAIL both_acks_seen: got %b, required 1", ok); else passed++;
        checks++; if (sbq.size() !== 0) $display("FAIL both_drain: got %0d pending, required 0", sbq.size()); else passed++;
    endtask

    task automatic test_timeout();
        int g, base;
        do_reset();
        base = n_ack_i + n_ack_d;
        lat = 100000;
        @(posedge CLK); #1;
        daddr = 32'h60; dREN = 1'b1;
        @(posedge CLK);
        g = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK);
            if (ramREN && !err) g++;
        end
        checks++; if (g !== 16) $display("FAIL to_grant_cycles: got %0d, required 16", g); else passed++;
        @(negedge CLK);
        checks++; if (err !== 1'b1) $display("FAIL to_err: got %b, required 1", err); else passed++;
        checks++; if (ramREN !== 1'b0) $display("FAIL to_idle: ramREN got %b, required 0", ramREN); else passed++;
        dREN = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (err !== 1'b1) $display("FAIL to_sticky: got %b, required 1", err); else passed++;
        checks++; if (n_ack_i + n_ack_d !== base) $display("FAIL to_no_ack: got %0d acks, required %0d", n_ack_i + n_ack_d, base); else passed++;
        do_reset();
        @(negedge CLK);
        checks++; if (err !== 1'b0) $display("FAIL to_err_reset: got %b, required 0", err); else passed++;
    endtask

    task automatic test_drop();
        int base_d;
        do_reset();
        base_d = n_ack_d;
        lat = 100000;
        @(posedge CLK); #1;
        daddr = 32'h70; dREN = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checks++; if (ramREN !== 1'b1) $display("FAIL drop_granted: ramREN got %b, required 1", ramREN); else passed++;
        @(posedge CLK); #1 dREN = 1'b0;
        @(posedge CLK); #1 iaddr = 32'h90; iREN = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checks++; if (!(ramREN === 1'b1 && ramaddr === 32'h90))
            $display("FAIL drop_idle_next: ramREN=%b ramaddr=%h, required 1/00000090", ramREN, ramaddr);
        else passed++;
        iREN = 1'b0;
        @(negedge CLK);
        checks++; if (err !== 1'b0) $display("FAIL drop_err: got %b, required 0", err); else passed++;
        checks++; if (n_ack_d !== base_d) $display("FAIL drop_no_ack: got %0d d acks, required %0d", n_ack_d, base_d); else passed++;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        lat = 100000;
        @(posedge CLK); #1;
        iaddr = 32'h24; iREN = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checks++; if (ramREN !== 1'b1) $display("FAIL rmid_granted: ramREN got %b, required 1", ramREN); else passed++;
        #2 nRST = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b0) $display("FAIL rmid_ramREN: got %b, required 0", ramREN); else passed++;
        checks++; if (iwait !== 1'b1) $display("FAIL rmid_iwait: got %b, required 1", iwait); else passed++;
        checks++; if (ramaddr !== '0) $display("FAIL rmid_idle: ramaddr got %h, required 0", ramaddr); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL rmid_err: got %b, required 0", err); else passed++;
        iREN = 1'b0;
        @(posedge CLK); #1 nRST = 1'b1;
        @(negedge CLK);
        checks++; if (ramREN !== 1'b0 || err !== 1'b0)
            $display("FAIL rmid_after: ramREN=%b err=%b, required 0/0", ramREN, err);
        else passed++;
        lat = 1;
    endtask

    task automatic test_error_held();
        int base;
        bit ok;
        do_reset();
        base = n_ack_i + n_ack_d;
        lat = 4;
        sbq.push_back('{1'b1, 1'b1, pat(32'h30)});
        @(posedge CLK); #1;
        daddr = 32'h30; dREN = 1'b1;
        @(posedge CLK);
        @(posedge CLK); #1 inj = 1'b1;
        @(posedge CLK); #1 inj = 1'b0;
        checks++; if (err !== 1'b1) $display("FAIL error_set: got %b, required 1", err); else passed++;
        wait_acks(base + 1, 20, ok);
        dREN = 1'b0;
        checks++; if (ok !== 1'b1) $display("FAIL error_grant_held: ack seen %b, required 1", ok); else passed++;
        checks++; if (sbq.size() !== 0) $display("FAIL error_drain: got %0d pending, required 0", sbq.size()); else passed++;
        lat = 1;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_read();
        test_fixed_prio_write();
        test_both_held();
        test_timeout();
        test_drop();
        test_reset_mid_grant();
        test_error_held();
        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
